// File: rtl/seq_restoring_divider_pkg.sv
// rtl/seq_restoring_divider_pkg.sv - shared state encoding and sizing helpers for the restoring divider
package seq_restoring_divider_pkg;

    // Default operand width and the matching iteration-counter width
    localparam int DIV_WIDTH = 8;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Counter width for an arbitrary operand width; never narrower than one bit
    function automatic int div_cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_sub.sv
// rtl/seq_restoring_divider_sub.sv - combinational subtract-with-borrow used for the trial subtraction
module div_sub_stage #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] sum;

    // Two's-complement subtract: a carry out of the top bit means no borrow
    always_comb begin
        sum    = {1'b0, minuend} + {1'b0, ~subtrahend} + {{WIDTH{1'b0}}, 1'b1};
        diff   = sum[WIDTH-1:0];
        borrow = ~sum[WIDTH];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle unsigned restoring divider with start/busy/done handshake
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = div_cnt_width(WIDTH);

    div_state_t state;
    div_state_t state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             restore;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;

    assign accept = (state == ST_IDLE) && start;

    // P holds only WIDTH bits: after each step it is below D (or, with D=0,
    // a prefix of the dividend), so the extra bit only exists in the shifted value
    assign p_sh = {p, q[WIDTH-1]};

    div_sub_stage #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .minuend   (p_sh),
        .subtrahend({1'b0, d}),
        .diff      (trial),
        .borrow    (borrow)
    );

    // Trial went negative: borrow out of the adder or sign bit set; the two agree for any reachable P
    assign restore = borrow | trial[WIDTH];
    assign p_next  = restore ? p_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_next  = {q[WIDTH-2:0], ~restore};

    // State register plus registered handshake outputs derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
            done  <= (state_next == ST_DONE);
        end
    end

    // Next-state logic: one pass through RUN per quotient bit, then a single DONE cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (cnt == '0) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, shift-subtract iterations, result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            p           <= '0;
            q           <= '0;
            d           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt         <= CW'(WIDTH - 1);
            p           <= '0;
            q           <= dividend;
            d           <= divisor;
            div_by_zero <= (divisor == '0);
        end else if (state == ST_RUN) begin
            p <= p_next;
            q <= q_next;
            if (cnt == '0) begin
                quotient  <= q_next;
                remainder <= p_next;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed and swept checks of the restoring divider at widths 8 and 4
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    logic       start4 = 1'b0;
    logic [3:0] dividend4 = '0;
    logic [3:0] divisor4 = '0;
    logic       busy4, done4, div_by_zero4;
    logic [3:0] quotient4, remainder4;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    seq_restoring_divider #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .dividend   (dividend4),
        .divisor    (divisor4),
        .busy       (busy4),
        .done       (done4),
        .quotient   (quotient4),
        .remainder  (remainder4),
        .div_by_zero(div_by_zero4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    // One width-8 division: latency, busy length, single done pulse, results
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic ez,
                           input bit full);
        int busy_n, done_n, done_at;
        wait_idle();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h3C;
        busy_n = 0;
        done_n = 0;
        done_at = -1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = i;
            end
            if (!busy) break;
        end
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_lat"}, done_at, 8);
        if (full) begin
            check({tag, "_dbz"}, div_by_zero, ez);
            check({tag, "_done_n"}, done_n, 1);
            check({tag, "_busy_n"}, busy_n, 9);
        end
    endtask

    task automatic run_div4(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] eq, input logic [3:0] er);
        int done_at;
        dividend4 = a;
        divisor4  = b;
        start4    = 1'b1;
        @(posedge clk); #1;
        start4    = 1'b0;
        done_at   = -1;
        for (int i = 1; i < 12; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                done_at = i;
                break;
            end
        end
        check({tag, "_lat"}, done_at, 4);
        check({tag, "_q"}, quotient4, eq);
        check({tag, "_r"}, remainder4, er);
        @(posedge clk); #1;
        check({tag, "_idle"}, busy4, 0);
    endtask

    logic [7:0] hv_a [4];
    logic [7:0] hv_b [4];
    logic [7:0] hv_q [4];
    logic [7:0] hv_r [4];

    initial begin
        int k, dn;
        logic [7:0] ra, rb;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        run_div("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b1);
        run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1);
        run_div("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b1);
        run_div("d100_0", 8'd100, 8'd0, 8'd255, 8'd100, 1'b1, 1'b1);
        run_div("d0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 1'b1);

        // Start held high: accepts every 10 edges, operands only matter on those edges
        hv_a[0] = 8'd50;  hv_b[0] = 8'd6;   hv_q[0] = 8'd8;  hv_r[0] = 8'd2;
        hv_a[1] = 8'd13;  hv_b[1] = 8'd13;  hv_q[1] = 8'd1;  hv_r[1] = 8'd0;
        hv_a[2] = 8'd250; hv_b[2] = 8'd16;  hv_q[2] = 8'd15; hv_r[2] = 8'd10;
        hv_a[3] = 8'd9;   hv_b[3] = 8'd200; hv_q[3] = 8'd0;  hv_r[3] = 8'd9;
        wait_idle();
        for (int t = 0; t < 40; t++) begin
            start = 1'b1;
            if (t % 10 == 0) begin
                dividend = hv_a[t / 10];
                divisor  = hv_b[t / 10];
            end else begin
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
            @(posedge clk); #1;
            k = t / 10;
            if (t % 10 == 8) begin
                check($sformatf("hold%0d_done", k), done, 1);
                check($sformatf("hold%0d_q", k), quotient, hv_q[k]);
                check($sformatf("hold%0d_r", k), remainder, hv_r[k]);
            end else if (t % 10 == 9) begin
                check($sformatf("hold%0d_idle", k), busy, 0);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;

        // Async reset in the middle of a run
        wait_idle();
        dividend = 8'd77;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_r", remainder, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("arst_no_done", dn, 0);
        run_div("d77_3", 8'd77, 8'd3, 8'd25, 8'd2, 1'b0, 1'b1);

        // Random sweep against / and %
        for (int i = 0; i < 1500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom_range(1, 255));
            run_div($sformatf("rnd%0d_%0d_%0d", i, ra, rb), ra, rb, ra / rb, ra % rb, 1'b0, 1'b0);
        end

        // Width 4 corners
        run_div4("w4_15_15", 4'd15, 4'd15, 4'd1, 4'd0);
        run_div4("w4_0_15", 4'd0, 4'd15, 4'd0, 4'd0);
        run_div4("w4_14_3", 4'd14, 4'd3, 4'd4, 4'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
